// File: rtl/fifo_write_arbiter.sv
// Write side of an async FIFO with two requesters sharing the single write port.
// Round-robin arbitration, Gray write pointer, and pessimistic full/almost-full/fill tracking.
module fifo_write_arbiter #(
   parameter int ADDRESS_SIZE      = 3,
   parameter int ALMOST_FULL_LEVEL = 6
) (
   input  logic                    write_clk,
   input  logic                    write_reset_n,
   input  logic                    req0,
   input  logic                    req1,
   input  logic [7:0]              data0,
   input  logic [7:0]              data1,
   input  logic [ADDRESS_SIZE:0]   sync_read_pointer,
   input  logic                    clear_error,
   output logic                    grant0,
   output logic                    grant1,
   output logic                    write_enable,
   output logic [ADDRESS_SIZE-1:0] write_address,
   output logic [7:0]              write_data,
   output logic [ADDRESS_SIZE:0]   write_pointer,
   output logic                    full,
   output logic                    almost_full,
   output logic [ADDRESS_SIZE:0]   fill_level,
   output logic                    overflow_error
);

   localparam int PW    = ADDRESS_SIZE + 1;
   localparam int DEPTH = 1 << ADDRESS_SIZE;

   logic [PW-1:0] wbin_q, wbin_d;
   logic [PW-1:0] wgray_q, wgray_d;
   logic [PW-1:0] fill_q, fill_d;
   logic          rr_q, rr_d;
   logic          full_q, full_d;
   logic          afull_q, afull_d;
   logic          ovf_q, ovf_d;
   logic [PW-1:0] rbin;
   logic [PW-1:0] occ;

   // Grants are gated by reset so nothing is accepted while the pointers are held.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (write_reset_n && !full_q) begin
         if (req0 && req1) begin
            grant0 = ~rr_q;
            grant1 = rr_q;
         end else begin
            grant0 = req0;
            grant1 = req1;
         end
      end
   end

   assign write_enable  = grant0 | grant1;
   assign write_address = wbin_q[ADDRESS_SIZE-1:0];
   assign write_data    = grant1 ? data1 : data0;

   always_comb begin
      rbin = '0;
      rbin[PW-1] = sync_read_pointer[PW-1];
      for (int i = PW - 2; i >= 0; i--)
         rbin[i] = rbin[i+1] ^ sync_read_pointer[i];
   end

   // Occupancy uses the stale synchronized read pointer, so flags can only err toward full.
   always_comb begin
      wbin_d  = wbin_q + {{(PW-1){1'b0}}, write_enable};
      wgray_d = (wbin_d >> 1) ^ wbin_d;
      occ     = wbin_d - rbin;
      fill_d  = occ;
      full_d  = (32'(occ) == 32'(DEPTH));
      afull_d = (32'(occ) >= 32'(ALMOST_FULL_LEVEL));
      rr_d    = rr_q;
      if (grant0)
         rr_d = 1'b1;
      else if (grant1)
         rr_d = 1'b0;
      ovf_d = (full_q & (req0 | req1)) | (ovf_q & ~clear_error);
   end

   always_ff @(posedge write_clk or negedge write_reset_n) begin
      if (!write_reset_n) begin
         wbin_q  <= '0;
         wgray_q <= '0;
         fill_q  <= '0;
         rr_q    <= 1'b0;
         full_q  <= 1'b0;
         afull_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wgray_q <= wgray_d;
         fill_q  <= fill_d;
         rr_q    <= rr_d;
         full_q  <= full_d;
         afull_q <= afull_d;
         ovf_q   <= ovf_d;
      end
   end

   assign write_pointer  = wgray_q;
   assign full           = full_q;
   assign almost_full    = afull_q;
   assign fill_level     = fill_q;
   assign overflow_error = ovf_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a count-based occupancy model.
module tb_fifo_write_arbiter;

   logic       write_clk = 1'b0;
   logic       write_reset_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0, clear_error = 1'b0;
   logic [7:0] data0 = '0, data1 = '0;
   logic [3:0] sync_read_pointer = '0;
   logic       grant0, grant1, write_enable, full, almost_full, overflow_error;
   logic [2:0] write_address;
   logic [7:0] write_data;
   logic [3:0] write_pointer, fill_level;

   int nvec = 0;
   int nerr = 0;

   fifo_write_arbiter #(.ADDRESS_SIZE(3), .ALMOST_FULL_LEVEL(6)) dut (
      .write_clk(write_clk), .write_reset_n(write_reset_n),
      .req0(req0), .req1(req1), .data0(data0), .data1(data1),
      .sync_read_pointer(sync_read_pointer), .clear_error(clear_error),
      .grant0(grant0), .grant1(grant1), .write_enable(write_enable),
      .write_address(write_address), .write_data(write_data),
      .write_pointer(write_pointer), .full(full), .almost_full(almost_full),
      .fill_level(fill_level), .overflow_error(overflow_error)
   );

   always #5 write_clk = ~write_clk;

   typedef struct packed {
      logic       g0, g1, we;
      logic [2:0] addr;
      logic [7:0] wd;
      logic [3:0] wp;
      logic       full, af;
      logic [3:0] fill;
      logic       ovf;
   } out_t;

   typedef struct {
      logic       r0, r1;
      logic [7:0] d0, d1;
      logic [3:0] rp;
      logic       clr;
      out_t       exp;
   } vec_t;

   out_t act;
   assign act = {grant0, grant1, write_enable, write_address, write_data, write_pointer,
                 full, almost_full, fill_level, overflow_error};

   function automatic logic [3:0] gray(input int b);
      logic [3:0] v;
      v = 4'(b % 16);
      return v ^ (v >> 1);
   endfunction

   function automatic out_t mo(input logic g0, g1, input int addr, input logic [7:0] wd,
                               input logic [3:0] wp, input logic f, af, input int fill,
                               input logic ovf);
      out_t o;
      o = {g0, g1, g0 | g1, 3'(addr), wd, wp, f, af, 4'(fill), ovf};
      return o;
   endfunction

   task automatic check(input string name, input out_t exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got g0g1we=%b%b%b addr=%0d wd=%h wp=%h full=%b af=%b fill=%0d ovf=%b, expected g0g1we=%b%b%b addr=%0d wd=%h wp=%h full=%b af=%b fill=%0d ovf=%b",
                  name, act.g0, act.g1, act.we, act.addr, act.wd, act.wp, act.full, act.af,
                  act.fill, act.ovf, exp.g0, exp.g1, exp.we, exp.addr, exp.wd, exp.wp,
                  exp.full, exp.af, exp.fill, exp.ovf);
      end
   endtask

   task automatic do_reset();
      write_reset_n = 1'b0;
      @(negedge write_clk);
      @(negedge write_clk);
      write_reset_n = 1'b1;
   endtask

   vec_t tbl[15];

   // Model state for the random phase: plain write/read counts, not pointers.
   int         wcnt, rcnt, fill_m;
   logic       prio, full_m, af_m, ovf_m;
   logic       g0_m, g1_m, r0, r1, clr;
   logic [7:0] d0, d1;

   initial begin
      for (int i = 0; i < 8; i++)
         tbl[i] = '{1'b1, 1'b0, 8'h10 + 8'(i), 8'hEE, 4'h0, 1'b0,
                    mo(1, 0, i, 8'h10 + 8'(i), gray(i), 0, i >= 6, i, 0)};
      tbl[8]  = '{1'b0, 1'b1, 8'h55, 8'hAA, 4'h0, 1'b0, mo(0, 0, 0, 8'h55, 4'hC, 1, 1, 8, 0)};
      tbl[9]  = '{1'b0, 1'b0, 8'h55, 8'hAA, 4'h0, 1'b0, mo(0, 0, 0, 8'h55, 4'hC, 1, 1, 8, 1)};
      tbl[10] = '{1'b0, 1'b0, 8'h55, 8'hAA, 4'h0, 1'b1, mo(0, 0, 0, 8'h55, 4'hC, 1, 1, 8, 1)};
      tbl[11] = '{1'b0, 1'b0, 8'h55, 8'hAA, 4'h0, 1'b0, mo(0, 0, 0, 8'h55, 4'hC, 1, 1, 8, 0)};
      tbl[12] = '{1'b0, 1'b0, 8'h55, 8'hAA, 4'h1, 1'b0, mo(0, 0, 0, 8'h55, 4'hC, 1, 1, 8, 0)};
      tbl[13] = '{1'b0, 1'b0, 8'h55, 8'hAA, 4'h3, 1'b0, mo(0, 0, 0, 8'h55, 4'hC, 0, 1, 7, 0)};
      tbl[14] = '{1'b0, 1'b0, 8'h55, 8'hAA, 4'h3, 1'b0, mo(0, 0, 0, 8'h55, 4'hC, 0, 1, 6, 0)};

      // Reset with a request present: nothing may be granted.
      req0 = 1'b1; data0 = 8'h99;
      #2;
      check("reset_state", mo(0, 0, 0, 8'h99, 4'h0, 0, 0, 0, 0));
      @(negedge write_clk);
      write_reset_n = 1'b1;

      // Fill to full, overflow, clear, then the reader drains two entries.
      foreach (tbl[i]) begin
         req0 = tbl[i].r0; req1 = tbl[i].r1; data0 = tbl[i].d0; data1 = tbl[i].d1;
         sync_read_pointer = tbl[i].rp; clear_error = tbl[i].clr;
         #1;
         check($sformatf("table[%0d]", i), tbl[i].exp);
         @(negedge write_clk);
      end
      req0 = 0; req1 = 0; clear_error = 0;

      // Both requesting from reset: grants alternate starting with requester 0.
      sync_read_pointer = '0;
      do_reset();
      req0 = 1; req1 = 1;
      for (int k = 0; k < 4; k++) begin
         data0 = 8'h20 + 8'(k); data1 = 8'h40 + 8'(k);
         #1;
         check($sformatf("alternate[%0d]", k),
               mo(k % 2 == 0, k % 2 == 1, k, (k % 2 == 0) ? 8'h20 + 8'(k) : 8'h40 + 8'(k),
                  gray(k), 0, 0, k, 0));
         @(negedge write_clk);
      end
      req0 = 0; req1 = 0;

      // Sixteen writes with the reader caught up: Gray pointer wraps through 8 back to 0.
      sync_read_pointer = '0;
      do_reset();
      for (int k = 0; k <= 16; k++) begin
         req0 = (k < 16); data0 = 8'(k);
         sync_read_pointer = gray(k);
         #1;
         check($sformatf("gray_wrap[%0d]", k),
               mo(k < 16, 0, k % 8, 8'(k), gray(k), 0, 0, (k == 0) ? 0 : 1, 0));
         @(negedge write_clk);
      end
      req0 = 0;

      // Reset asserted mid-burst at wbin=5, then first write lands at address 0.
      sync_read_pointer = '0;
      do_reset();
      req0 = 1; data0 = 8'h77;
      for (int k = 0; k < 5; k++) @(negedge write_clk);
      #1;
      check("pre_reset_wbin5", mo(1, 0, 5, 8'h77, gray(5), 0, 0, 5, 0));
      #1;
      write_reset_n = 1'b0;
      #1;
      check("async_reset", mo(0, 0, 0, 8'h77, 4'h0, 0, 0, 0, 0));
      @(negedge write_clk);
      write_reset_n = 1'b1;
      #1;
      check("post_reset_first", mo(1, 0, 0, 8'h77, 4'h0, 0, 0, 0, 0));
      @(negedge write_clk);
      req0 = 0;

      // Randomized traffic against the count model.
      sync_read_pointer = '0;
      do_reset();
      wcnt = 0; rcnt = 0; fill_m = 0; prio = 0; full_m = 0; af_m = 0; ovf_m = 0;
      for (int i = 0; i < 400; i++) begin
         r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
         d0 = 8'($urandom); d1 = 8'($urandom);
         clr = ($urandom_range(0, 7) == 0);
         if (rcnt < wcnt && $urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 2 : 7))
            rcnt++;
         req0 = r0; req1 = r1; data0 = d0; data1 = d1; clear_error = clr;
         sync_read_pointer = gray(rcnt);
         g0_m = !full_m && r0 && (!r1 || !prio);
         g1_m = !full_m && r1 && (!r0 || prio);
         #1;
         check($sformatf("random[%0d]", i),
               mo(g0_m, g1_m, wcnt % 8, g1_m ? d1 : d0, gray(wcnt), full_m, af_m, fill_m, ovf_m));
         ovf_m = (full_m && (r0 || r1)) || (ovf_m && !clr);
         if (g0_m) prio = 1;
         if (g1_m) prio = 0;
         wcnt += int'(g0_m | g1_m);
         fill_m = wcnt - rcnt;
         full_m = (fill_m == 8);
         af_m = (fill_m >= 6);
         @(negedge write_clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter ADDRESS_SIZE, default 3, FIFO address width; depth = 2^ADDRESS_SIZE.
REQ-002 Parameter ALMOST_FULL_LEVEL, default 6, fill level at or above which almost_full asserts.
REQ-003 write_clk  input  1  write-domain clock; all state updates on rising edge.
REQ-004 write_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req0, req1  input  1 each  write request from requester 0 and requester 1.
REQ-006 data0, data1  input  8 each  write data from requester 0 and requester 1.
REQ-007 sync_read_pointer  input  ADDRESS_SIZE+1  Gray-coded read pointer, already two-flop synchronized into write_clk.
REQ-008 clear_error  input  1  clears overflow_error.
REQ-009 grant0, grant1  output  1 each  combinational accept for requester 0 and requester 1; at most one high.
REQ-010 write_enable  output  1  memory write strobe; equals grant0|grant1.
REQ-011 write_address  output  ADDRESS_SIZE  memory address; equals binary write pointer[ADDRESS_SIZE-1:0].
REQ-012 write_data  output  8  data of the granted requester; data0 when none granted.
REQ-013 write_pointer  output  ADDRESS_SIZE+1  registered Gray write pointer, for the write-to-read synchronizer.
REQ-014 full, almost_full  output  1 each  registered status flags.
REQ-015 fill_level  output  ADDRESS_SIZE+1  registered occupancy, 0..depth.
REQ-016 overflow_error  output  1  sticky: request made while full.

Function
REQ-017 Internal binary pointer wbin, ADDRESS_SIZE+1 bits; write_pointer = registered (wbin>>1)^wbin; both wrap modulo 2^(ADDRESS_SIZE+1).
REQ-018 Grant only when full=0 and the requester's req=1.
REQ-019 Single requester: grant to that requester in the same cycle.
REQ-020 Both requesting: grant goes to requester holding priority; priority register rr (0 or 1) selects.
REQ-021 After any grant, rr set to the non-granted index; with no grant, rr holds.
REQ-022 On a grant, wbin and write_pointer advance by exactly 1 at the next edge; one write per cycle maximum.
REQ-023 rbin = Gray-to-binary of sync_read_pointer, combinational.
REQ-024 Next-state occupancy = (wbin_next - rbin) mod 2^(ADDRESS_SIZE+1); registered into fill_level.
REQ-025 full next = (next Gray pointer == {~sync_read_pointer[MSB:MSB-1], sync_read_pointer[MSB-2:0]}); equivalently fill_level==depth.
REQ-026 almost_full next = (occupancy >= ALMOST_FULL_LEVEL).
REQ-027 Flags deassert only as sync_read_pointer advances; read-side progress is visible after synchronizer latency (pessimistic, never optimistic).
REQ-028 overflow_error sets at edge when full=1 and (req0|req1)=1; clear_error clears it; simultaneous set and clear -> set wins.
REQ-029 A request during full is not granted, not written, and does not change rr.
REQ-030 Pointer wrap: after 2^(ADDRESS_SIZE+1) writes, wbin returns to 0 and the Gray sequence stays single-bit-change across the wrap.

Reset
REQ-031 write_reset_n low asynchronously forces wbin=0, write_pointer=0, rr=0, full=0, almost_full=0, fill_level=0, overflow_error=0.
REQ-032 During reset, grant0=grant1=write_enable=0, regardless of req.
REQ-033 Reset asserted mid-burst discards the in-flight grant; first grant after release writes address 0.

Verification
REQ-034 Reset, sync_read_pointer=0, req0=1 for 8 cycles -> addresses 0..7 written, full=1 after 8th edge, fill_level=8, almost_full rose after 6th edge.
REQ-035 Full, req1=1 one cycle -> no grant, write_enable=0, overflow_error=1; clear_error pulse -> 0.
REQ-036 Both req held, not full -> grants alternate 0,1,0,1 starting with requester 0; write_data tracks data0/data1 accordingly.
REQ-037 Full, then sync_read_pointer steps Gray 0->1->3 -> full drops one cycle after first step, fill_level 8->7->6.
REQ-038 16 writes with reader keeping pace -> write_pointer follows Gray sequence 0,1,3,2,...,8,0 with single-bit changes incl. wrap.
REQ-039 Reset asserted while req0=1 at wbin=5 -> all outputs to reset values immediately; after release, first write at address 0.
